// File: rtl/deadlock_cycle_recorder_if.sv
// Record-FIFO read bus of the deadlock cycle recorder: one record per beat,
// transferred when rec_valid and rec_ready are both high.
interface deadlock_cycle_recorder_if #(
    parameter int IDXW = 2
) ();
    logic            rec_valid;
    logic            rec_ready;
    logic [IDXW-1:0] rec_idx;
    logic            rec_last;
    logic [7:0]      rec_cycle_id;

    modport master (
        output rec_valid,
        output rec_idx,
        output rec_last,
        output rec_cycle_id,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_idx,
        input  rec_last,
        input  rec_cycle_id,
        output rec_ready
    );
endinterface

// File: rtl/deadlock_cycle_recorder.sv
// Detects a persistent deadlock indication, walks each dependence cycle starting
// from the lowest pending process, and logs its members into a record FIFO.
module deadlock_cycle_recorder #(
    parameter int PROC_NUM       = 4,
    parameter int DEPTH          = 16,
    parameter int STALL_CYCLES   = 8,
    parameter int REPORT_TIMEOUT = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [PROC_NUM-1:0]       dl_in_vec,
    output logic                      dl_detect_out,
    output logic [PROC_NUM-1:0]       origin,
    output logic                      token_clear,
    output logic [7:0]                cycle_count,
    output logic                      done,
    output logic                      overflow,
    output logic                      timeout,
    deadlock_cycle_recorder_if.master rec_if
);

    localparam int IDXW = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1;
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int SW   = $clog2(STALL_CYCLES + 1);
    localparam int TW   = $clog2(REPORT_TIMEOUT + 1);
    localparam int RECW = 8 + 1 + IDXW;

    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(REPORT_TIMEOUT - 1);
    localparam logic [CW-1:0] FIFO_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DETECTED = 2'd1,
        S_REPORT   = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    function automatic logic [PROC_NUM-1:0] f_lowest_onehot(input logic [PROC_NUM-1:0] v);
        f_lowest_onehot = v & (~v + {{(PROC_NUM-1){1'b0}}, 1'b1});
    endfunction

    function automatic logic [IDXW-1:0] f_low_index(input logic [PROC_NUM-1:0] v);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDXW'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [IDXW-1:0] f_high_index(input logic [PROC_NUM-1:0] v);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < PROC_NUM; i++) begin
            if (v[i]) begin
                idx = IDXW'(i);
            end
        end
        return idx;
    endfunction

    state_t              r_state;
    logic [SW-1:0]       r_stall;
    logic [TW-1:0]       r_tmo_cnt;
    logic [PROC_NUM-1:0] r_dl_detect;
    logic [PROC_NUM-1:0] r_dl_done;
    logic [PROC_NUM-1:0] r_origin;
    logic [PROC_NUM-1:0] r_last_vec;
    logic [7:0]          r_cycle_id;

    logic [RECW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;

    logic [PROC_NUM-1:0] w_pending;
    logic [PROC_NUM-1:0] w_origin_oh;
    logic                w_close;
    logic                w_tmo;
    logic                w_member;
    logic                w_track;
    logic                w_push;
    logic [RECW-1:0]     w_push_rec;
    logic                w_rec_valid;
    logic                w_pop;
    logic                w_full;
    logic                w_wr_en;
    logic [RECW-1:0]     w_head;

    assign w_pending   = r_dl_detect & ~r_dl_done;
    assign w_origin_oh = f_lowest_onehot(w_pending);

    assign dl_detect_out = |r_dl_detect;
    assign origin        = (r_state == S_DETECTED) ? w_origin_oh : '0;

    // Per-cycle decode of close/timeout/member events and the record to push.
    always_comb begin
        w_close    = 1'b0;
        w_tmo      = 1'b0;
        w_member   = 1'b0;
        w_track    = 1'b0;
        w_push     = 1'b0;
        w_push_rec = '0;
        case (r_state)
            S_DETECTED: begin
                if (|w_pending) begin
                    w_push     = 1'b1;
                    w_push_rec = {r_cycle_id, 1'b0, f_low_index(w_origin_oh)};
                end else begin
                    w_push     = 1'b0;
                end
            end
            S_REPORT: begin
                w_close  = |(dl_in_vec & r_origin);
                w_tmo    = !w_close && (r_tmo_cnt == TMO_MAX);
                w_member = !w_close && !w_tmo && (|dl_in_vec) && (dl_in_vec != r_last_vec);
                w_track  = |(dl_in_vec & r_dl_detect);
                // A closing beat (real or forced by timeout) suppresses any member record.
                if (w_close || w_tmo) begin
                    w_push     = 1'b1;
                    w_push_rec = {r_cycle_id, 1'b1, f_low_index(r_origin)};
                end else if (w_member) begin
                    w_push     = 1'b1;
                    w_push_rec = {r_cycle_id, 1'b0, f_high_index(dl_in_vec)};
                end else begin
                    w_push     = 1'b0;
                end
            end
            default: begin
                w_push = 1'b0;
            end
        endcase
    end

    // Detection, cycle walking and sticky status flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_stall     <= '0;
            r_tmo_cnt   <= '0;
            r_dl_detect <= '0;
            r_dl_done   <= '0;
            r_origin    <= '0;
            r_last_vec  <= '0;
            r_cycle_id  <= 8'd0;
            token_clear <= 1'b0;
            cycle_count <= 8'd0;
            done        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            token_clear <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|dl_in_vec) begin
                        if (r_stall == STALL_MAX) begin
                            r_dl_detect <= dl_in_vec;
                            r_stall     <= '0;
                            r_state     <= S_DETECTED;
                        end else begin
                            r_stall <= r_stall + SW'(1);
                        end
                    end else begin
                        r_stall <= '0;
                    end
                end
                S_DETECTED: begin
                    if (|w_pending) begin
                        r_origin   <= w_origin_oh;
                        r_last_vec <= w_origin_oh;
                        r_tmo_cnt  <= '0;
                        r_state    <= S_REPORT;
                    end else begin
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_REPORT: begin
                    // Timed-out origins are retired so the walk always makes progress.
                    r_dl_done <= r_dl_done | (w_track ? dl_in_vec : '0) | (w_tmo ? r_origin : '0);
                    if (w_close || w_tmo) begin
                        token_clear <= 1'b1;
                        r_cycle_id  <= r_cycle_id + 8'd1;
                        if (cycle_count != 8'hFF) begin
                            cycle_count <= cycle_count + 8'd1;
                        end else begin
                            cycle_count <= cycle_count;
                        end
                        if (w_tmo) begin
                            timeout <= 1'b1;
                        end else begin
                            timeout <= timeout;
                        end
                        r_state <= S_DETECTED;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                        if (w_member) begin
                            r_last_vec <= dl_in_vec;
                        end else begin
                            r_last_vec <= r_last_vec;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_rec_valid = (r_count != '0);
    assign w_full      = (r_count == FIFO_FULL);
    assign w_pop       = w_rec_valid & rec_if.rec_ready;
    assign w_wr_en     = w_push & (!w_full | w_pop);

    // FIFO pointers, occupancy and overflow flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) begin
                overflow <= 1'b1;
            end else begin
                overflow <= overflow;
            end
        end
    end

    // Record storage; contents are only observed through the valid-masked head.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_push_rec;
        end
    end

    assign w_head              = r_mem[r_rd_ptr];
    assign rec_if.rec_valid    = w_rec_valid;
    assign rec_if.rec_idx      = w_rec_valid ? w_head[IDXW-1:0] : '0;
    assign rec_if.rec_last     = w_rec_valid & w_head[IDXW];
    assign rec_if.rec_cycle_id = w_rec_valid ? w_head[RECW-1:IDXW+1] : 8'd0;

endmodule

// File: tb/tb_deadlock_cycle_recorder.sv
// Randomized scoreboard bench for deadlock_cycle_recorder against a procedural
// reference model of the detection / cycle-walk / record-FIFO rules.
module tb_deadlock_cycle_recorder;
    localparam int P  = 4;
    localparam int D  = 8;
    localparam int ST = 4;
    localparam int TO = 16;
    localparam int IW = 2;

    localparam int PH_IDLE = 0;
    localparam int PH_DET  = 1;
    localparam int PH_REP  = 2;
    localparam int PH_DONE = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [P-1:0] dl_in_vec = '0;
    logic         dl_detect_out;
    logic [P-1:0] origin;
    logic         token_clear;
    logic [7:0]   cycle_count;
    logic         done;
    logic         overflow;
    logic         timeout;

    deadlock_cycle_recorder_if #(.IDXW(IW)) rec_if ();

    deadlock_cycle_recorder #(
        .PROC_NUM(P), .DEPTH(D), .STALL_CYCLES(ST), .REPORT_TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset), .dl_in_vec(dl_in_vec),
        .dl_detect_out(dl_detect_out), .origin(origin), .token_clear(token_clear),
        .cycle_count(cycle_count), .done(done), .overflow(overflow), .timeout(timeout),
        .rec_if(rec_if)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0]    cid;
        logic          last;
        logic [IW-1:0] idx;
    } rec_t;

    rec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int           m_phase, m_stall, m_to, m_org, m_cnt, m_cid, m_ccount;
    logic [P-1:0] m_det, m_dn, m_lastv;
    bit           m_done, m_ovf, m_tmo, m_tc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [P-1:0] v);
        for (int i = 0; i < P; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int highest(input logic [P-1:0] v);
        for (int i = P - 1; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE; m_stall = 0; m_to = 0; m_org = 0; m_cnt = 0;
        m_cid = 0; m_ccount = 0; m_det = '0; m_dn = '0; m_lastv = '0;
        m_done = 0; m_ovf = 0; m_tmo = 0; m_tc = 0;
        sb.delete();
    endtask

    // Predict the effect of the coming clock edge given the inputs just applied.
    task automatic model_step(input logic [P-1:0] v, input bit r);
        bit           pop, push, closing, tmo;
        rec_t         rec;
        logic [P-1:0] pend;
        pop  = (m_cnt > 0) && r;
        push = 0;
        rec  = '0;
        m_tc = 0;
        case (m_phase)
            PH_IDLE: begin
                if (v != '0) begin
                    if (m_stall == ST - 1) begin
                        m_det = v; m_stall = 0; m_phase = PH_DET;
                    end else m_stall++;
                end else m_stall = 0;
            end
            PH_DET: begin
                pend = m_det & ~m_dn;
                if (pend != '0) begin
                    m_org = lowest(pend);
                    push = 1; rec.cid = 8'(m_cid); rec.last = 1'b0; rec.idx = IW'(m_org);
                    m_lastv = '0; m_lastv[m_org] = 1'b1;
                    m_to = 0; m_phase = PH_REP;
                end else begin
                    m_done = 1; m_phase = PH_DONE;
                end
            end
            PH_REP: begin
                closing = v[m_org];
                tmo = !closing && (m_to == TO - 1);
                if ((v & m_det) != '0) m_dn = m_dn | v;
                if (closing || tmo) begin
                    push = 1; rec.cid = 8'(m_cid); rec.last = 1'b1; rec.idx = IW'(m_org);
                    m_tc = 1;
                    m_cid = (m_cid + 1) % 256;
                    if (m_ccount < 255) m_ccount++;
                    if (tmo) begin m_tmo = 1; m_dn[m_org] = 1'b1; end
                    m_phase = PH_DET;
                end else begin
                    m_to++;
                    if (v != '0 && v != m_lastv) begin
                        push = 1; rec.cid = 8'(m_cid); rec.last = 1'b0; rec.idx = IW'(highest(v));
                        m_lastv = v;
                    end
                end
            end
            default: ;
        endcase
        if (push) begin
            if (m_cnt < D || pop) begin
                sb.push_back(rec);
                m_cnt++;
            end else m_ovf = 1;
        end
        if (pop) m_cnt--;
    endtask

    task automatic check_status();
        logic [P-1:0] exp_org;
        exp_org = '0;
        if (m_phase == PH_DET && lowest(m_det & ~m_dn) >= 0) exp_org[lowest(m_det & ~m_dn)] = 1'b1;
        chk("dl_detect_out", 32'(dl_detect_out), 32'(m_det != '0));
        chk("origin",        32'(origin),        32'(exp_org));
        chk("token_clear",   32'(token_clear),   32'(m_tc));
        chk("cycle_count",   32'(cycle_count),   32'(m_ccount));
        chk("done",          32'(done),          32'(m_done));
        chk("overflow",      32'(overflow),      32'(m_ovf));
        chk("timeout",       32'(timeout),       32'(m_tmo));
        chk("rec_valid",     32'(rec_if.rec_valid), 32'(m_cnt > 0));
    endtask

    task automatic check_reset_outputs();
        chk("rst_dl_detect_out", 32'(dl_detect_out), 32'd0);
        chk("rst_origin",        32'(origin),        32'd0);
        chk("rst_token_clear",   32'(token_clear),   32'd0);
        chk("rst_cycle_count",   32'(cycle_count),   32'd0);
        chk("rst_flags",         32'({done, overflow, timeout}), 32'd0);
        chk("rst_rec_valid",     32'(rec_if.rec_valid), 32'd0);
        chk("rst_rec_fields",    32'({rec_if.rec_cycle_id, rec_if.rec_last, rec_if.rec_idx}), 32'd0);
    endtask

    task automatic cyc(input logic [P-1:0] v, input bit r);
        @(posedge clock);
        #1;
        check_status();
        dl_in_vec = v;
        rec_if.rec_ready = r;
        model_step(v, r);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2;
        reset = 1'b0;
        dl_in_vec = '0;
        rec_if.rec_ready = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic hold(input logic [P-1:0] v, input bit r, input int n);
        for (int i = 0; i < n; i++) cyc(v, r);
    endtask

    // Scoreboard monitor: compares every record the DUT hands over.
    always @(negedge clock) begin
        rec_t exp_r;
        if (reset) begin
            if (rec_if.rec_valid && rec_if.rec_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_record actual cid=%0d last=%0d idx=%0d required=none",
                             rec_if.rec_cycle_id, rec_if.rec_last, rec_if.rec_idx);
                end else begin
                    exp_r = sb.pop_front();
                    chk("rec_cycle_id", 32'(rec_if.rec_cycle_id), 32'(exp_r.cid));
                    chk("rec_last",     32'(rec_if.rec_last),     32'(exp_r.last));
                    chk("rec_idx",      32'(rec_if.rec_idx),      32'(exp_r.idx));
                end
            end else if (!rec_if.rec_valid) begin
                chk("rec_idle_zero", 32'({rec_if.rec_cycle_id, rec_if.rec_last, rec_if.rec_idx}), 32'd0);
            end
        end
    end

    initial begin
        logic [P-1:0] v;
        rec_if.rec_ready = 1'b0;
        model_reset();
        #2;
        check_reset_outputs();
        @(negedge clock);
        reset = 1'b1;

        // glitch shorter than the stall window
        hold(4'b0001, 1'b1, 3);
        hold(4'b0000, 1'b1, 4);

        // single dependence cycle
        do_reset();
        hold(4'b0011, 1'b1, 4);
        cyc(4'b0010, 1'b1);
        cyc(4'b0010, 1'b1);
        cyc(4'b0001, 1'b1);
        hold(4'b0000, 1'b1, 4);

        // two cycles from one detection
        do_reset();
        hold(4'b0101, 1'b1, 4);
        cyc(4'b0000, 1'b1);
        cyc(4'b0001, 1'b1);
        cyc(4'b0000, 1'b1);
        cyc(4'b0100, 1'b1);
        hold(4'b0000, 1'b1, 4);

        // overflow with reader stalled, then drain in order
        do_reset();
        hold(4'b1111, 1'b0, 4);
        cyc(4'b0000, 1'b0);
        for (int i = 0; i < 8; i++) cyc((i % 2 == 0) ? 4'b0010 : 4'b0100, 1'b0);
        cyc(4'b0001, 1'b0);
        hold(4'b0000, 1'b1, 30);

        // report timeout
        do_reset();
        hold(4'b0001, 1'b1, 4);
        cyc(4'b0000, 1'b1);
        hold(4'b0000, 1'b1, TO + 4);

        // reset while reporting with three buffered records
        do_reset();
        hold(4'b1111, 1'b0, 4);
        cyc(4'b0000, 1'b0);
        cyc(4'b0010, 1'b0);
        cyc(4'b0100, 1'b0);
        do_reset();
        hold(4'b0001, 1'b1, 3);
        cyc(4'b0000, 1'b1);
        hold(4'b0001, 1'b1, 4);
        hold(4'b0000, 1'b1, 20);

        // randomized episodes, each started by a reset at an arbitrary point
        for (int e = 0; e < 12; e++) begin
            do_reset();
            for (int c = 0; c < 250; c++) begin
                v = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
                cyc(v, $urandom_range(0, 3) != 0);
            end
        end

        hold(4'b0000, 1'b1, 20);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
